rv32im_dmem_ctrl: RTL

Data-memory access controller sitting directly downstream of the execute stage's load/store path. It accepts one load/store request per transaction (address, store data, LSU opcode) over a valid/ready handshake. It drives a word-aligned request/grant/rvalid data bus with byte enables, and returns sign/zero-extended load data or an error to the writeback stage. The core pipeline stalls while the block is not ready.

---
 rtl/rv32im_dmem_ctrl_pkg.sv | 53 +++++
 rtl/rv32im_dmem_align.sv | 83 ++++++++
 rtl/rv32im_dmem_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rv32im_dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_ctrl_pkg
// Shared definitions for the data-memory access controller:
//   - LSU opcode encoding (LB/LH/LW/LBU/LHU/SB/SH/SW) and access size helpers
//   - DMEM_CAUSE_* response cause codes
//   - DMEM controller FSM state encoding
// -----------------------------------------------------------------------------
package rv32im_dmem_ctrl_pkg;

    localparam int LSU_OPCODE_WIDTH = 3;

    typedef enum logic [LSU_OPCODE_WIDTH-1:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_SZ_BYTE = 2'd0,
        LSU_SZ_HALF = 2'd1,
        LSU_SZ_WORD = 2'd2
    } lsu_size_e;

    localparam logic [1:0] DMEM_CAUSE_NONE     = 2'b00;
    localparam logic [1:0] DMEM_CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] DMEM_CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] DMEM_CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_ADDR = 2'd1,
        DMEM_WAIT = 2'd2,
        DMEM_RESP = 2'd3
    } dmem_state_e;

    function automatic lsu_size_e lsu_size(input lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: lsu_size = LSU_SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: lsu_size = LSU_SZ_HALF;
            default:                 lsu_size = LSU_SZ_WORD;
        endcase
    endfunction

    function automatic logic lsu_is_store(input lsu_op_e op);
        lsu_is_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/rv32im_dmem_align.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_align
// Purely combinational lane logic for a 32-bit little-endian data bus.
// Request side (from the incoming op):
//   i_req_op, i_req_addr_lo, i_req_wdata -> o_req_be, o_req_wdata (lane
//   replicated, zero for loads), o_req_we, o_req_misaligned
// Load side (from the captured op and the returned bus word):
//   i_ld_op, i_ld_addr_lo, i_ld_rdata -> o_ld_data (sign/zero extended,
//   zero for store opcodes)
// -----------------------------------------------------------------------------
module rv32im_dmem_align
    import rv32im_dmem_ctrl_pkg::*;
(
    input  lsu_op_e     i_req_op,
    input  logic [1:0]  i_req_addr_lo,
    input  logic [31:0] i_req_wdata,
    output logic [3:0]  o_req_be,
    output logic [31:0] o_req_wdata,
    output logic        o_req_we,
    output logic        o_req_misaligned,
    input  lsu_op_e     i_ld_op,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    lsu_size_e   w_req_size;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Store data is replicated across every lane so the byte enables alone
    // select where it lands; the shift is implicit.
    always_comb begin
        w_req_size       = lsu_size(i_req_op);
        o_req_we         = lsu_is_store(i_req_op);
        o_req_be         = 4'b0000;
        o_req_wdata      = '0;
        o_req_misaligned = 1'b0;
        case (w_req_size)
            LSU_SZ_BYTE: begin
                o_req_be    = 4'b0001 << i_req_addr_lo;
                o_req_wdata = {4{i_req_wdata[7:0]}};
            end
            LSU_SZ_HALF: begin
                o_req_be         = 4'b0011 << {i_req_addr_lo[1], 1'b0};
                o_req_wdata      = {2{i_req_wdata[15:0]}};
                o_req_misaligned = i_req_addr_lo[0];
            end
            LSU_SZ_WORD: begin
                o_req_be         = 4'b1111;
                o_req_wdata      = i_req_wdata;
                o_req_misaligned = |i_req_addr_lo;
            end
            default: ;
        endcase
        if (!o_req_we) begin
            o_req_wdata = '0;
        end
    end

    always_comb begin
        w_ld_byte = i_ld_rdata[7:0];
        case (i_ld_addr_lo)
            2'd0: w_ld_byte = i_ld_rdata[7:0];
            2'd1: w_ld_byte = i_ld_rdata[15:8];
            2'd2: w_ld_byte = i_ld_rdata[23:16];
            2'd3: w_ld_byte = i_ld_rdata[31:24];
            default: ;
        endcase
        w_ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

        o_ld_data = '0;
        case (i_ld_op)
            LSU_LB:  o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            LSU_LBU: o_ld_data = {24'd0, w_ld_byte};
            LSU_LH:  o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            LSU_LHU: o_ld_data = {16'd0, w_ld_half};
            LSU_LW:  o_ld_data = i_ld_rdata;
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/rv32im_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// rv32im_dmem_ctrl
// Data-memory access controller between the execute-stage LSU and a
// word-aligned req/gnt/rvalid data bus.
// Ports:
//   clk_i, rst_ni               clock, synchronous active-low reset
//   req_valid_i / req_ready_o   LSU request handshake: a request is taken on a
//                               cycle where both are high; the requester holds
//                               lsu_opcode_i/addr_i/wdata_i stable until then
//   lsu_opcode_i, addr_i, wdata_i  op, byte address, unshifted store data
//   resp_valid_o, resp_rdata_o, resp_err_o, resp_cause_o
//                               one-cycle response strobe with load data/error
//   busy_o                      controller not idle (pipeline stall)
//   bus_req_o/we/be/addr/wdata  bus request, held stable until bus_gnt_i
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i   bus responses
//   dbg_state_o                 current FSM state
// -----------------------------------------------------------------------------
module rv32im_dmem_ctrl
    import rv32im_dmem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [LSU_OPCODE_WIDTH-1:0] lsu_opcode_i,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    output logic                        resp_valid_o,
    output logic [DATA_WIDTH-1:0]       resp_rdata_o,
    output logic                        resp_err_o,
    output logic [1:0]                  resp_cause_o,
    output logic                        busy_o,
    output logic                        bus_req_o,
    output logic                        bus_we_o,
    output logic [3:0]                  bus_be_o,
    output logic [ADDR_WIDTH-1:0]       bus_addr_o,
    output logic [DATA_WIDTH-1:0]       bus_wdata_o,
    input  logic                        bus_gnt_i,
    input  logic                        bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]       bus_rdata_i,
    input  logic                        bus_err_i,
    output dmem_state_e                 dbg_state_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_e           r_state;
    logic [CNT_W-1:0]      r_cnt;
    lsu_op_e               r_op;
    logic [1:0]            r_addr_lo;
    logic                  r_bus_req;
    logic                  r_bus_we;
    logic [3:0]            r_bus_be;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_wdata;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic [1:0]            r_resp_cause;

    lsu_op_e               w_req_op;
    logic                  w_accept;
    logic [3:0]            w_req_be;
    logic [DATA_WIDTH-1:0] w_req_wdata;
    logic                  w_req_we;
    logic                  w_req_misaligned;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic                  w_last_cycle;

    assign w_req_op     = lsu_op_e'(lsu_opcode_i);
    assign req_ready_o  = (r_state == DMEM_IDLE) & rst_ni;
    assign w_accept     = req_valid_i & req_ready_o;
    // Last cycle of the ADDR+WAIT budget; the counter starts at 0 on accept.
    assign w_last_cycle = (r_cnt == CNT_LAST);

    rv32im_dmem_align u_align (
        .i_req_op         (w_req_op),
        .i_req_addr_lo    (addr_i[1:0]),
        .i_req_wdata      (wdata_i),
        .o_req_be         (w_req_be),
        .o_req_wdata      (w_req_wdata),
        .o_req_we         (w_req_we),
        .o_req_misaligned (w_req_misaligned),
        .i_ld_op          (r_op),
        .i_ld_addr_lo     (r_addr_lo),
        .i_ld_rdata       (bus_rdata_i),
        .o_ld_data        (w_ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= DMEM_IDLE;
            r_cnt        <= '0;
            r_op         <= LSU_LB;
            r_addr_lo    <= 2'b00;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_be     <= 4'b0000;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= DMEM_CAUSE_NONE;
        end else begin
            case (r_state)
                DMEM_IDLE: begin
                    if (w_accept) begin
                        r_op      <= w_req_op;
                        r_addr_lo <= addr_i[1:0];
                        r_cnt     <= '0;
                        if (w_req_misaligned) begin
                            // Rejected before touching the bus.
                            r_state      <= DMEM_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= DMEM_CAUSE_MISALIGN;
                        end else begin
                            r_state     <= DMEM_ADDR;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= w_req_we;
                            r_bus_be    <= w_req_be;
                            r_bus_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            r_bus_wdata <= w_req_wdata;
                        end
                    end
                end

                DMEM_ADDR: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Timeout wins over a grant on the final cycle so the
                    // budget is never exceeded; any late response is dropped.
                    if (w_last_cycle) begin
                        r_bus_req    <= 1'b0;
                        r_state      <= DMEM_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= DMEM_CAUSE_TIMEOUT;
                    end else if (bus_gnt_i) begin
                        // A same-cycle rvalid is not a valid bus response here.
                        r_bus_req <= 1'b0;
                        r_state   <= DMEM_WAIT;
                    end
                end

                DMEM_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Data already on the bus is taken even on the last cycle.
                    if (bus_rvalid_i) begin
                        r_state      <= DMEM_RESP;
                        r_resp_valid <= 1'b1;
                        if (bus_err_i) begin
                            r_resp_rdata <= '0;
                            r_resp_err   <= 1'b1;
                            r_resp_cause <= DMEM_CAUSE_BUS_ERR;
                        end else begin
                            r_resp_rdata <= w_ld_data;
                            r_resp_err   <= 1'b0;
                            r_resp_cause <= DMEM_CAUSE_NONE;
                        end
                    end else if (w_last_cycle) begin
                        r_state      <= DMEM_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= DMEM_CAUSE_TIMEOUT;
                    end
                end

                DMEM_RESP: begin
                    r_state      <= DMEM_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= 1'b0;
                    r_resp_cause <= DMEM_CAUSE_NONE;
                end

                default: r_state <= DMEM_IDLE;
            endcase
        end
    end

    assign busy_o       = (r_state != DMEM_IDLE);
    assign bus_req_o    = r_bus_req;
    assign bus_we_o     = r_bus_we;
    assign bus_be_o     = r_bus_be;
    assign bus_addr_o   = r_bus_addr;
    assign bus_wdata_o  = r_bus_wdata;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_resp_rdata;
    assign resp_err_o   = r_resp_err;
    assign resp_cause_o = r_resp_cause;
    assign dbg_state_o  = r_state;

endmodule
